// File: rtl/counter_mod_n_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
package counter_pkg;

  localparam int unsigned MODE_SAT  = 0;
  localparam int unsigned MODE_WRAP = 1;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Prescale counter width; a ratio of 1 still keeps a 1-bit register.
  function automatic int unsigned presc_width(input int unsigned prescale);
    int unsigned w;
    w = (prescale <= 1) ? 1 : $clog2(prescale);
    return w;
  endfunction

endpackage : counter_pkg

// File: rtl/counter_mod_n_if.sv
// Control and status bundle of a counter_mod_n instance.
interface counter_mod_n_if #(
  parameter int unsigned WIDTH = 7
);

  logic             i_en;
  logic             i_dir;
  logic             i_clear;
  logic             i_load;
  logic [WIDTH-1:0] i_load_val;

  logic [WIDTH-1:0] o_value;
  logic             o_at_max;
  logic             o_at_min;
  logic             o_wrap;
  logic             o_step;

  modport slave (
    input  i_en, i_dir, i_clear, i_load, i_load_val,
    output o_value, o_at_max, o_at_min, o_wrap, o_step
  );

  modport master (
    output i_en, i_dir, i_clear, i_load, i_load_val,
    input  o_value, o_at_max, o_at_min, o_wrap, o_step
  );

endinterface : counter_mod_n_if

// File: rtl/counter_mod_n_prescaler.sv
// Counts enabled cycles 0..PRESCALE-1 and flags the cycle that completes a period.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  input  logic i_sync_clr,
  output logic o_tick
);

  localparam int unsigned   PW      = presc_width(PRESCALE);
  localparam logic [PW-1:0] PC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pc_q;
  logic [PW-1:0] pc_d;

  assign o_tick = i_en && (pc_q == PC_LAST);

  // Clear wins; a completed period restarts the phase, disabled cycles hold it.
  always_comb begin
    pc_d = pc_q;
    if (i_sync_clr) begin
      pc_d = '0;
    end else if (o_tick) begin
      pc_d = '0;
    end else if (i_en) begin
      pc_d = pc_q + PW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule : tick_prescaler

// File: rtl/counter_mod_n.sv
// Parametrised modulo-N counter with prescaler, wrap/saturate mode, clear and load.
module counter_mod_n
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 7,
  parameter int unsigned CNT_MAX  = 99,
  parameter int unsigned MODE     = 1,
  parameter int unsigned PRESCALE = 1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  counter_mod_n_if.slave  bus
);

  if ((64'(CNT_MAX) >> WIDTH) != 64'd0) begin : g_bad_width
    $fatal(1, "counter_mod_n: CNT_MAX does not fit in WIDTH bits");
  end
  if (CNT_MAX < 1) begin : g_bad_max
    $fatal(1, "counter_mod_n: CNT_MAX must be at least 1");
  end
  if (PRESCALE < 1) begin : g_bad_presc
    $fatal(1, "counter_mod_n: PRESCALE must be at least 1");
  end
  if (MODE > MODE_WRAP) begin : g_bad_mode
    $fatal(1, "counter_mod_n: MODE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(CNT_MAX);
  localparam logic             WRAP  = (MODE == MODE_WRAP);

  logic [WIDTH-1:0] value_q,  value_d;
  logic             wrap_q,   wrap_d;
  logic             step_q,   step_d;
  logic             at_max_q, at_min_q;
  logic [WIDTH-1:0] load_clamped;
  logic             tick;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_presc (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_en       (bus.i_en),
    .i_sync_clr (bus.i_clear | bus.i_load),
    .o_tick     (tick)
  );

  assign load_clamped = (bus.i_load_val > MAX_V) ? MAX_V : bus.i_load_val;

  // Boundary is tested before the arithmetic so no value outside 0..CNT_MAX is formed.
  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    step_d  = 1'b0;
    if (bus.i_clear) begin
      value_d = '0;
    end else if (bus.i_load) begin
      value_d = load_clamped;
    end else if (tick) begin
      step_d = 1'b1;
      if (bus.i_dir == DIR_UP) begin
        if (value_q < MAX_V) begin
          value_d = value_q + WIDTH'(1);
        end else if (WRAP) begin
          value_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (value_q != '0) begin
          value_d = value_q - WIDTH'(1);
        end else if (WRAP) begin
          value_d = MAX_V;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  // Boundary flags are decoded from the next value so they land with it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      value_q  <= '0;
      wrap_q   <= 1'b0;
      step_q   <= 1'b0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
    end else begin
      value_q  <= value_d;
      wrap_q   <= wrap_d;
      step_q   <= step_d;
      at_max_q <= (value_d == MAX_V);
      at_min_q <= (value_d == '0);
    end
  end

  assign bus.o_value  = value_q;
  assign bus.o_wrap   = wrap_q;
  assign bus.o_step   = step_q;
  assign bus.o_at_max = at_max_q;
  assign bus.o_at_min = at_min_q;

endmodule : counter_mod_n

// File: tb/tb_counter_mod_n.sv
// Bench for counter_mod_n: four configurations driven in parallel against an arithmetic model.
module tb_counter_mod_n;

  localparam int unsigned W = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en, dir, clr, ld;
  logic [W-1:0] lv;

  always #5 clk = ~clk;

  counter_mod_n_if #(.WIDTH(W)) bus_a ();
  counter_mod_n_if #(.WIDTH(W)) bus_b ();
  counter_mod_n_if #(.WIDTH(W)) bus_c ();
  counter_mod_n_if #(.WIDTH(W)) bus_d ();

  counter_mod_n #(.WIDTH(W), .CNT_MAX(99), .MODE(1), .PRESCALE(1))
    u_a (.i_clk(clk), .i_reset_n(rst_n), .bus(bus_a.slave));
  counter_mod_n #(.WIDTH(W), .CNT_MAX(9),  .MODE(0), .PRESCALE(1))
    u_b (.i_clk(clk), .i_reset_n(rst_n), .bus(bus_b.slave));
  counter_mod_n #(.WIDTH(W), .CNT_MAX(9),  .MODE(1), .PRESCALE(3))
    u_c (.i_clk(clk), .i_reset_n(rst_n), .bus(bus_c.slave));
  counter_mod_n #(.WIDTH(W), .CNT_MAX(99), .MODE(1), .PRESCALE(4))
    u_d (.i_clk(clk), .i_reset_n(rst_n), .bus(bus_d.slave));

  assign bus_a.i_en = en;  assign bus_a.i_dir = dir;  assign bus_a.i_clear = clr;
  assign bus_a.i_load = ld; assign bus_a.i_load_val = lv;
  assign bus_b.i_en = en;  assign bus_b.i_dir = dir;  assign bus_b.i_clear = clr;
  assign bus_b.i_load = ld; assign bus_b.i_load_val = lv;
  assign bus_c.i_en = en;  assign bus_c.i_dir = dir;  assign bus_c.i_clear = clr;
  assign bus_c.i_load = ld; assign bus_c.i_load_val = lv;
  assign bus_d.i_en = en;  assign bus_d.i_dir = dir;  assign bus_d.i_clear = clr;
  assign bus_d.i_load = ld; assign bus_d.i_load_val = lv;

  logic [W-1:0] o_val [4];
  logic         o_wrp [4];
  logic         o_stp [4];
  logic         o_max [4];
  logic         o_min [4];

  assign o_val[0] = bus_a.o_value; assign o_wrp[0] = bus_a.o_wrap; assign o_stp[0] = bus_a.o_step;
  assign o_max[0] = bus_a.o_at_max; assign o_min[0] = bus_a.o_at_min;
  assign o_val[1] = bus_b.o_value; assign o_wrp[1] = bus_b.o_wrap; assign o_stp[1] = bus_b.o_step;
  assign o_max[1] = bus_b.o_at_max; assign o_min[1] = bus_b.o_at_min;
  assign o_val[2] = bus_c.o_value; assign o_wrp[2] = bus_c.o_wrap; assign o_stp[2] = bus_c.o_step;
  assign o_max[2] = bus_c.o_at_max; assign o_min[2] = bus_c.o_at_min;
  assign o_val[3] = bus_d.o_value; assign o_wrp[3] = bus_d.o_wrap; assign o_stp[3] = bus_d.o_step;
  assign o_max[3] = bus_d.o_at_max; assign o_min[3] = bus_d.o_at_min;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: count value and number of enabled cycles into the current period.
  int m_val [4];
  int m_cnt [4];
  bit m_wrap [4];
  bit m_step [4];

  function automatic int cmax_of(input int i);
    return (i == 1 || i == 2) ? 9 : 99;
  endfunction

  function automatic int ps_of(input int i);
    return (i == 2) ? 3 : (i == 3) ? 4 : 1;
  endfunction

  function automatic bit wraps(input int i);
    return (i != 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 0; m_cnt[i] = 0; m_wrap[i] = 1'b0; m_step[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      int cm;
      cm = cmax_of(i);
      m_wrap[i] = 1'b0;
      m_step[i] = 1'b0;
      if (clr) begin
        m_val[i] = 0; m_cnt[i] = 0;
      end else if (ld) begin
        m_val[i] = (int'(lv) > cm) ? cm : int'(lv);
        m_cnt[i] = 0;
      end else if (en) begin
        m_cnt[i] = (m_cnt[i] + 1) % ps_of(i);
        if (m_cnt[i] == 0) begin
          m_step[i] = 1'b1;
          if (!dir) begin
            if (wraps(i)) begin
              m_wrap[i] = (m_val[i] == cm);
              m_val[i]  = (m_val[i] + 1) % (cm + 1);
            end else begin
              m_val[i] = (m_val[i] + 1 > cm) ? cm : m_val[i] + 1;
            end
          end else begin
            if (wraps(i)) begin
              m_wrap[i] = (m_val[i] == 0);
              m_val[i]  = (m_val[i] + cm) % (cm + 1);
            end else begin
              m_val[i] = (m_val[i] == 0) ? 0 : m_val[i] - 1;
            end
          end
        end
      end
    end
  endtask

  task automatic expect_v(input string name, input int i, input int e_val, input bit e_wrap,
                          input bit e_step, input bit e_max, input bit e_min);
    vectors++;
    if (int'(o_val[i]) != e_val || o_wrp[i] !== e_wrap || o_stp[i] !== e_step ||
        o_max[i] !== e_max || o_min[i] !== e_min) begin
      miscompares++;
      $display("FAIL %s inst%0d: got val=%0d wrap=%b step=%b max=%b min=%b, want val=%0d wrap=%b step=%b max=%b min=%b",
               name, i, o_val[i], o_wrp[i], o_stp[i], o_max[i], o_min[i],
               e_val, e_wrap, e_step, e_max, e_min);
    end
  endtask

  task automatic check_model(input string name);
    for (int i = 0; i < 4; i++) begin
      expect_v(name, i, m_val[i], m_wrap[i], m_step[i],
               m_val[i] == cmax_of(i), m_val[i] == 0);
    end
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    model_edge();
    #1;
    check_model(name);
  endtask

  // Reset is asserted between edges and checked before any edge arrives.
  task automatic do_reset(input string name);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model(name);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_in(input logic c, input logic l, input logic [W-1:0] v,
                        input logic e, input logic d);
    clr = c; ld = l; lv = v; en = e; dir = d;
  endtask

  typedef struct {
    logic         clr, ld;
    logic [W-1:0] lv;
    logic         en, dir;
    int           e_val;
    bit           e_wrap, e_step, e_max, e_min;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int n_en;
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    model_reset();

    // Expectations for the CNT_MAX=99, wrap, PRESCALE=1 instance.
    tbl[0] = '{1'b0, 1'b1, 7'd120, 1'b0, 1'b0, 99, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 7'd0,   1'b1, 1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 7'd0,   1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 7'd50,  1'b1, 1'b0, 0,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 7'd0,   1'b1, 1'b1, 99, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 7'd0,   1'b1, 1'b1, 98, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 7'd57,  1'b0, 1'b0, 57, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 7'd0,   1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 7'd0,   1'b1, 1'b1, 0,  1'b0, 1'b0, 1'b0, 1'b1};

    #12;
    check_model("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Free-running up count through two wraps.
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 1; k <= 205; k++) begin
      tick("run");
      expect_v("run_a", 0, k % 100, (k % 100) == 0, 1'b1, (k % 100) == 99, (k % 100) == 0);
    end

    // Saturating instance: up past the top, then down past zero.
    do_reset("rst2");
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      tick("sat_up");
      expect_v("sat_up_b", 1, (k > 9) ? 9 : k, 1'b0, 1'b1, k >= 9, 1'b0);
    end
    dir = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick("sat_dn");
      expect_v("sat_dn_b", 1, (k > 9) ? 0 : 9 - k, 1'b0, 1'b1, 1'b0, k >= 9);
    end

    // Prescale 3 with gaps in the enable.
    do_reset("rst3");
    n_en = 0;
    for (int k = 0; k < 30; k++) begin
      set_in(1'b0, 1'b0, '0, (k % 4) != 2, 1'b0);
      tick("presc");
      if (en) n_en++;
      expect_v("presc_c", 2, (n_en / 3) % 10, en && (n_en % 3 == 0) && (n_en % 30 == 0),
               en && (n_en % 3 == 0), (n_en / 3) % 10 == 9, (n_en / 3) % 10 == 0);
    end

    // Load, clear and priority vectors.
    do_reset("rst4");
    for (int t = 0; t < 10; t++) begin
      set_in(tbl[t].clr, tbl[t].ld, tbl[t].lv, tbl[t].en, tbl[t].dir);
      tick("tbl");
      expect_v($sformatf("tbl%0d", t), 0, tbl[t].e_val, tbl[t].e_wrap, tbl[t].e_step,
               tbl[t].e_max, tbl[t].e_min);
    end

    // Reset in the middle of a prescale period discards value and phase.
    set_in(1'b0, 1'b1, 7'd57, 1'b1, 1'b0);
    tick("pre_rst_ld");
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick("pre_rst_1");
    tick("pre_rst_2");
    expect_v("d_at57", 3, 57, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    expect_v("d_async_rst", 3, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick("post_rst");
      expect_v("d_post_rst", 3, (k == 4) ? 1 : 0, 1'b0, k == 4, 1'b0, k != 4);
    end

    // Randomised traffic; direction bias flips every 250 cycles to reach both ends.
    do_reset("rst5");
    for (int k = 0; k < 1500; k++) begin
      logic bias_dn;
      bias_dn = ((k / 250) % 2) == 1;
      set_in(($urandom % 40) == 0, ($urandom % 24) == 0, W'($urandom),
             ($urandom % 4) != 0, bias_dn ? (($urandom % 8) != 0) : (($urandom % 8) == 0));
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_counter_mod_n
